id_ex_stage: RTL and testbench

- ID/EX pipeline register for the 5-stage core; sits directly upstream of the ALU.
- Captures decoded operands and control from ID, then drives the ALU operand pair and 3-bit ALU control.
- Resolves operand forwarding from the EX/MEM and MEM/WB stages.
- Detects load-use hazards and converts stalls and flushes into bubbles.

---
 rtl/core_pkg.sv | 23 ++
 rtl/fwd_mux.sv | 29 ++
 rtl/id_ex_stage.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU op encodings and the
// control bundle that travels with an instruction down the pipeline.
package core_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/fwd_mux.sv
// Operand bypass select: newest in-flight producer wins, x0 always reads
// the stored register-file value.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] reg_data,
    input  logic [RA_W-1:0] exm_rd,
    input  logic            exm_we,
    input  logic [XLEN-1:0] exm_data,
    input  logic [RA_W-1:0] mwb_rd,
    input  logic            mwb_we,
    input  logic [XLEN-1:0] mwb_data,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = reg_data;
        if (rs != '0) begin
            if (exm_we && (exm_rd == rs)) begin
                data = exm_data;
            end else if (mwb_we && (mwb_rd == rs)) begin
                data = mwb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: operand forwarding, load-use
// hazard detection, and stall/flush handling that inserts bubbles.
module id_ex_stage #(
    parameter int XLEN = core_pkg::XLEN,
    parameter int RA_W = core_pkg::RA_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [RA_W-1:0] rs1_addr_i,
    input  logic [RA_W-1:0] rs2_addr_i,
    input  logic [RA_W-1:0] rd_addr_i,
    input  logic [2:0]      alu_ctrl_i,
    input  logic            alu_src_i,
    input  logic            reg_write_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic            mem_to_reg_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [RA_W-1:0] exm_rd_i,
    input  logic            exm_we_i,
    input  logic [XLEN-1:0] exm_data_i,
    input  logic [RA_W-1:0] mwb_rd_i,
    input  logic            mwb_we_i,
    input  logic [XLEN-1:0] mwb_data_i,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [2:0]      alu_ctrl_o,
    output logic [RA_W-1:0] rd_addr_o,
    output logic            reg_write_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            mem_to_reg_o,
    output logic            valid_o,
    output logic            hazard_o
);
    import core_pkg::*;

    logic            vld_p1;
    ctrl_t           ctrl_p1;
    logic [2:0]      alu_ctrl_p1;
    logic            alu_src_p1;
    logic [XLEN-1:0] rs1_data_p1, rs2_data_p1, imm_p1;
    logic [RA_W-1:0] rs1_addr_p1, rs2_addr_p1, rd_p1;

    logic            vld_nxt;
    ctrl_t           ctrl_nxt;
    logic [2:0]      alu_ctrl_nxt;
    logic            alu_src_nxt;
    logic [XLEN-1:0] rs1_data_nxt, rs2_data_nxt, imm_nxt;
    logic [RA_W-1:0] rs1_addr_nxt, rs2_addr_nxt, rd_nxt;

    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // A load in EX whose result the ID instruction needs cannot be bypassed in time.
    assign hazard_o = vld_p1 && ctrl_p1.mem_read && (rd_p1 != '0) && valid_i &&
                      ((rd_p1 == rs1_addr_i) || ((rd_p1 == rs2_addr_i) && !alu_src_i));

    // Next-state: a bubble (all zero) on flush or hazard, otherwise the ID slot.
    always_comb begin
        vld_nxt      = 1'b0;
        ctrl_nxt     = CTRL_BUBBLE;
        alu_ctrl_nxt = ALU_ADD;
        alu_src_nxt  = 1'b0;
        rs1_data_nxt = '0;
        rs2_data_nxt = '0;
        imm_nxt      = '0;
        rs1_addr_nxt = '0;
        rs2_addr_nxt = '0;
        rd_nxt       = '0;
        if (!flush_i && !hazard_o) begin
            vld_nxt      = valid_i;
            ctrl_nxt     = '{reg_write: reg_write_i, mem_read: mem_read_i,
                             mem_write: mem_write_i, mem_to_reg: mem_to_reg_i};
            alu_ctrl_nxt = alu_ctrl_i;
            alu_src_nxt  = alu_src_i;
            rs1_data_nxt = rs1_data_i;
            rs2_data_nxt = rs2_data_i;
            imm_nxt      = imm_i;
            rs1_addr_nxt = rs1_addr_i;
            rs2_addr_nxt = rs2_addr_i;
            rd_nxt       = rd_addr_i;
        end
    end

    // ---- ID -> EX register boundary ----
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld_p1      <= 1'b0;
            ctrl_p1     <= CTRL_BUBBLE;
            alu_ctrl_p1 <= ALU_ADD;
            alu_src_p1  <= 1'b0;
            rs1_data_p1 <= '0;
            rs2_data_p1 <= '0;
            imm_p1      <= '0;
            rs1_addr_p1 <= '0;
            rs2_addr_p1 <= '0;
            rd_p1       <= '0;
        end else if (!stall_i) begin
            vld_p1      <= vld_nxt;
            ctrl_p1     <= ctrl_nxt;
            alu_ctrl_p1 <= alu_ctrl_nxt;
            alu_src_p1  <= alu_src_nxt;
            rs1_data_p1 <= rs1_data_nxt;
            rs2_data_p1 <= rs2_data_nxt;
            imm_p1      <= imm_nxt;
            rs1_addr_p1 <= rs1_addr_nxt;
            rs2_addr_p1 <= rs2_addr_nxt;
            rd_p1       <= rd_nxt;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
        .rs(rs1_addr_p1), .reg_data(rs1_data_p1),
        .exm_rd(exm_rd_i), .exm_we(exm_we_i), .exm_data(exm_data_i),
        .mwb_rd(mwb_rd_i), .mwb_we(mwb_we_i), .mwb_data(mwb_data_i),
        .data(fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
        .rs(rs2_addr_p1), .reg_data(rs2_data_p1),
        .exm_rd(exm_rd_i), .exm_we(exm_we_i), .exm_data(exm_data_i),
        .mwb_rd(mwb_rd_i), .mwb_we(mwb_we_i), .mwb_data(mwb_data_i),
        .data(fwd_rs2)
    );

    assign data1_o      = fwd_rs1;
    assign data2_o      = alu_src_p1 ? imm_p1 : fwd_rs2;
    assign store_data_o = fwd_rs2;
    assign alu_ctrl_o   = alu_ctrl_p1;
    assign rd_addr_o    = rd_p1;
    // Gating by valid guarantees a bubble never causes a write or memory access.
    assign reg_write_o  = ctrl_p1.reg_write  & vld_p1;
    assign mem_read_o   = ctrl_p1.mem_read   & vld_p1;
    assign mem_write_o  = ctrl_p1.mem_write  & vld_p1;
    assign mem_to_reg_o = ctrl_p1.mem_to_reg & vld_p1;
    assign valid_o      = vld_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by
// randomized traffic, compared against a transaction-level reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [2:0]  alu_ctrl_i;
    logic        alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i;
    logic        stall_i, flush_i;
    logic [4:0]  exm_rd_i, mwb_rd_i;
    logic        exm_we_i, mwb_we_i;
    logic [31:0] exm_data_i, mwb_data_i;
    logic [31:0] data1_o, data2_o, store_data_o;
    logic [2:0]  alu_ctrl_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, hazard_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .alu_ctrl_i(alu_ctrl_i), .alu_src_i(alu_src_i),
        .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .mem_to_reg_i(mem_to_reg_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .exm_rd_i(exm_rd_i), .exm_we_i(exm_we_i), .exm_data_i(exm_data_i),
        .mwb_rd_i(mwb_rd_i), .mwb_we_i(mwb_we_i), .mwb_data_i(mwb_data_i),
        .data1_o(data1_o), .data2_o(data2_o), .store_data_o(store_data_o),
        .alu_ctrl_o(alu_ctrl_o), .rd_addr_o(rd_addr_o),
        .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .mem_to_reg_o(mem_to_reg_o),
        .valid_o(valid_o), .hazard_o(hazard_o)
    );

    // Reference model: the instruction currently held in EX, as one record.
    typedef struct {
        bit          valid;
        bit          rw, mr, mw, mtr, src;
        logic [2:0]  alu;
        logic [31:0] d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
    } instr_t;

    instr_t m;

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.mtr = 0; b.src = 0;
        b.alu = 3'b000; b.d1 = 0; b.d2 = 0; b.imm = 0;
        b.rs1 = 0; b.rs2 = 0; b.rd = 0;
        return b;
    endfunction

    function automatic logic [31:0] operand(logic [4:0] rs, logic [31:0] stored);
        if (rs == 0) return stored;
        if (exm_we_i && exm_rd_i == rs) return exm_data_i;
        if (mwb_we_i && mwb_rd_i == rs) return mwb_data_i;
        return stored;
    endfunction

    function automatic bit load_use();
        bit uses_rs1, uses_rs2;
        uses_rs1 = (rs1_addr_i == m.rd);
        uses_rs2 = (rs2_addr_i == m.rd) && !alu_src_i;
        return m.valid && m.mr && (m.rd != 0) && valid_i && (uses_rs1 || uses_rs2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] f2;
        f2 = operand(m.rs2, m.d2);
        chk({tag, ".data1"},  data1_o, operand(m.rs1, m.d1));
        chk({tag, ".data2"},  data2_o, m.src ? m.imm : f2);
        chk({tag, ".store"},  store_data_o, f2);
        chk({tag, ".alu"},    {29'd0, alu_ctrl_o}, {29'd0, m.alu});
        chk({tag, ".rd"},     {27'd0, rd_addr_o}, {27'd0, m.rd});
        chk({tag, ".ctrl"},   {28'd0, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o},
                              {28'd0, m.rw & m.valid, m.mr & m.valid, m.mw & m.valid, m.mtr & m.valid});
        chk({tag, ".valid"},  {31'd0, valid_o}, {31'd0, m.valid});
        chk({tag, ".hazard"}, {31'd0, hazard_o}, {31'd0, load_use()});
    endtask

    // One clock edge: apply the stage's update rule to the model.
    task automatic tick();
        bit hz;
        hz = load_use();
        @(posedge clk);
        if (!stall_i) begin
            if (flush_i || hz) m = bubble();
            else begin
                m.valid = valid_i; m.rw = reg_write_i; m.mr = mem_read_i;
                m.mw = mem_write_i; m.mtr = mem_to_reg_i; m.src = alu_src_i;
                m.alu = alu_ctrl_i; m.d1 = rs1_data_i; m.d2 = rs2_data_i;
                m.imm = imm_i; m.rs1 = rs1_addr_i; m.rs2 = rs2_addr_i; m.rd = rd_addr_i;
            end
        end
        #1;
    endtask

    task automatic set_id(input bit v, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [31:0] im, input logic [4:0] a1, input logic [4:0] a2,
                          input logic [4:0] rd, input logic [2:0] op, input bit src,
                          input bit rw, input bit mr, input bit mw, input bit mtr);
        valid_i = v; rs1_data_i = d1; rs2_data_i = d2; imm_i = im;
        rs1_addr_i = a1; rs2_addr_i = a2; rd_addr_i = rd; alu_ctrl_i = op;
        alu_src_i = src; reg_write_i = rw; mem_read_i = mr; mem_write_i = mw; mem_to_reg_i = mtr;
    endtask

    task automatic set_fwd(input logic [4:0] er, input bit ew, input logic [31:0] ed,
                           input logic [4:0] mr, input bit mw, input logic [31:0] md);
        exm_rd_i = er; exm_we_i = ew; exm_data_i = ed;
        mwb_rd_i = mr; mwb_we_i = mw; mwb_data_i = md;
    endtask

    initial begin
        m = bubble();
        rst_i = 0; stall_i = 0; flush_i = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);
        #3;
        check_all("reset");
        chk("reset.valid_k", {31'd0, valid_o}, 32'd0);
        @(negedge clk); rst_i = 1;

        // add x3,x1,x2 with rs1=5, rs2=7
        set_id(1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 3'b000, 0, 1, 0, 0, 0);
        tick(); #1;
        check_all("add");
        chk("add.data1_k", data1_o, 32'd5);
        chk("add.data2_k", data2_o, 32'd7);
        chk("add.rw_k", {31'd0, reg_write_o}, 32'd1);

        // Forwarding priority on rs1=x4
        set_id(1, 32'd1, 32'd2, 32'd0, 5'd4, 5'd6, 5'd8, 3'b001, 0, 1, 0, 0, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
        set_fwd(5'd4, 1, 32'h10, 5'd4, 1, 32'h20); #1;
        check_all("fwd_both");
        chk("fwd_both.k", data1_o, 32'h10);
        exm_we_i = 0; #1;
        check_all("fwd_mwb");
        chk("fwd_mwb.k", data1_o, 32'h20);

        // x0 is never forwarded
        set_fwd(5'd0, 1, 32'h10, 5'd0, 1, 32'h20);
        set_id(1, 32'd0, 32'd9, 32'd0, 5'd0, 5'd9, 5'd0, 3'b000, 0, 1, 0, 0, 0);
        tick();
        check_all("x0");
        chk("x0.k", data1_o, 32'd0);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Load-use hazard on rs1
        set_id(1, 32'd0, 32'd0, 32'd4, 5'd2, 5'd0, 5'd5, 3'b000, 1, 1, 1, 0, 1);
        tick();
        set_id(1, 32'd0, 32'd0, 32'd0, 5'd5, 5'd6, 5'd7, 3'b000, 0, 1, 0, 0, 0); #1;
        check_all("lu_rs1");
        chk("lu_rs1.k", {31'd0, hazard_o}, 32'd1);
        tick();
        check_all("lu_bubble");
        chk("lu_bubble.k", {30'd0, valid_o, reg_write_o}, 32'd0);
        chk("lu_bubble.hz", {31'd0, hazard_o}, 32'd0);

        // Load, then only rs2 matches but operand 2 is the immediate
        set_id(1, 32'd0, 32'd0, 32'd4, 5'd2, 5'd0, 5'd5, 3'b000, 1, 1, 1, 0, 1);
        tick();
        set_id(1, 32'd0, 32'd0, 32'd8, 5'd3, 5'd5, 5'd7, 3'b000, 1, 1, 0, 0, 0); #1;
        check_all("lu_imm");
        chk("lu_imm.k", {31'd0, hazard_o}, 32'd0);

        // Stall holds everything; flush during stall ignored
        set_id(1, 32'hA, 32'hB, 32'h0, 5'd10, 5'd11, 5'd12, 3'b111, 0, 1, 0, 0, 0);
        tick();
        stall_i = 1;
        for (int i = 0; i < 3; i++) begin
            set_id(1, $urandom, $urandom, $urandom, 5'd13, 5'd14, 5'd15, 3'b110, 0, 0, 0, 1, 0);
            flush_i = (i == 2);
            tick();
            check_all("stall");
            chk("stall.k", {29'd0, alu_ctrl_o}, 32'd7);
        end
        stall_i = 0;
        tick();
        check_all("flush");
        chk("flush.k", {31'd0, valid_o}, 32'd0);
        flush_i = 0;

        // Immediate operand while rs2 is forwarded
        set_id(1, 32'd1, 32'd2, 32'hFFFFFFFC, 5'd1, 5'd9, 5'd3, 3'b000, 1, 0, 0, 1, 0);
        tick();
        set_fwd(5'd9, 1, 32'h33, 5'd0, 0, 0); #1;
        check_all("imm");
        chk("imm.d2", data2_o, 32'hFFFFFFFC);
        chk("imm.st", store_data_o, 32'h33);
        set_fwd(0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-stall with a valid sub stored
        set_id(1, 32'd3, 32'd4, 32'd0, 5'd1, 5'd2, 5'd3, 3'b001, 0, 1, 0, 0, 0);
        tick();
        stall_i = 1;
        #2; rst_i = 0; #1;
        m = bubble();
        check_all("async_rst");
        chk("async_rst.k", {28'd0, valid_o, alu_ctrl_o}, 32'd0);
        @(negedge clk); rst_i = 1; stall_i = 0;
        tick();
        check_all("post_rst");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom,
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            set_fwd(5'($urandom_range(0, 7)), 1'($urandom), $urandom,
                    5'($urandom_range(0, 7)), 1'($urandom), $urandom);
            stall_i = ($urandom_range(0, 4) == 0);
            flush_i = ($urandom_range(0, 7) == 0);
            #1;
            check_all("rnd_pre");
            tick();
            check_all("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
